// File: rtl/seq_result_buffer_if.sv
// Handshake bundle between the sequence calculator, the result buffer and its consumer.
// The buffer takes the slave side; the producer/consumer pair takes the master side.
interface seq_result_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // Producer side
  logic             in_done;
  logic [WIDTH-1:0] in_result;
  logic             in_is_fib;
  logic             in_error;
  logic             in_ovrflow;

  // Consumer side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_is_fib;
  logic             out_error;
  logic             out_ovrflow;

  // Status
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [7:0]       drop_cnt;

  modport master (
    output in_done, in_result, in_is_fib, in_error, in_ovrflow, out_ready,
    input  out_valid, out_result, out_is_fib, out_error, out_ovrflow,
    input  full, empty, count, drop_cnt
  );

  modport slave (
    input  in_done, in_result, in_is_fib, in_error, in_ovrflow, out_ready,
    output out_valid, out_result, out_is_fib, out_error, out_ovrflow,
    output full, empty, count, drop_cnt
  );
endinterface

// File: rtl/seq_result_buffer.sv
// Result FIFO behind the sequence calculator. Each completed calculation (done, error or
// overflow exit) is queued with its flags; the head entry is presented to the consumer with a
// valid/ready handshake. Results arriving while full are dropped and counted (saturating).
module seq_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input logic               clk,
  input logic               resetN,
  seq_result_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic             is_fib;
    logic             error;
    logic             ovrflow;
    logic [WIDTH-1:0] result;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    drop_q;

  logic   full;
  logic   empty;
  logic   pop;
  logic   push;
  logic   drop;
  entry_t wr_entry;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A pop frees the slot on the same edge, so a push into a full buffer still lands.
  assign pop  = !empty && bus.out_ready;
  assign push = bus.in_done && (!full || pop);
  assign drop = bus.in_done && full && !pop;

  // Error exits carry no meaningful result and suppress the overflow flag.
  always_comb begin
    wr_entry.is_fib  = bus.in_is_fib;
    wr_entry.error   = bus.in_error;
    wr_entry.ovrflow = bus.in_ovrflow && !bus.in_error;
    wr_entry.result  = bus.in_error ? '0 : bus.in_result;
  end

  // Storage array; deliberately not reset, contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= wr_entry;
    end
  end

  // Pointers, occupancy and drop counter.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  // Head entry drives the consumer side directly; no bypass from the input.
  always_comb begin
    bus.out_valid   = !empty;
    bus.out_result  = mem[rptr_q].result;
    bus.out_is_fib  = mem[rptr_q].is_fib;
    bus.out_error   = mem[rptr_q].error;
    bus.out_ovrflow = mem[rptr_q].ovrflow;
    bus.full        = full;
    bus.empty       = empty;
    bus.count       = count_q;
    bus.drop_cnt    = drop_q;
  end
endmodule

// File: doc/seq_result_buffer.md
SEQ_RESULT_BUFFER -- requirements
Module: seq_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 Parameter WIDTH, default 16, result data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetN  input  1  reset, asynchronous, active-low.
REQ-005 in_done  input  1  one-cycle pulse from sequence calculator: result complete (its DONE, ERROR or OVRFLOW exit).
REQ-006 in_result  input  WIDTH  calculator result, valid only while in_done=1.
REQ-007 in_is_fib  input  1  1 = Fibonacci request, 0 = triangle request.
REQ-008 in_error  input  1  calculator rejected the request (ERROR path).
REQ-009 in_ovrflow  input  1  calculator result overflowed WIDTH (OVRFLOW path).
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_ready  input  1  consumer accepts head entry.
REQ-012 out_result  output  WIDTH  head entry result.
REQ-013 out_is_fib / out_error / out_ovrflow  output  1 each  head entry flags.
REQ-014 full / empty  output  1 each  FIFO occupancy flags.
REQ-015 count  output  log2(DEPTH)+1  entries stored, 0..DEPTH.
REQ-016 drop_cnt  output  8  results lost because buffer full; saturates at 255.

Function
REQ-017 Push: in_done=1 on a clock edge; entry {in_is_fib, in_error, in_ovrflow, in_result} written at tail.
REQ-018 Entry with in_error=1 stores result 0 regardless of in_result; in_ovrflow stored as given; in_error=1 takes precedence, out_ovrflow stored 0.
REQ-019 Pop: out_valid=1 and out_ready=1 on a clock edge; head advances.
REQ-020 out_valid = !empty; out_* driven combinationally from head entry; out_* hold while out_valid=1 and out_ready=0.
REQ-021 Latency: entry pushed at edge N appears on out_* after edge N when buffer empty; no same-cycle bypass from in_* to out_*.
REQ-022 out_ready with out_valid=0: no effect, no pointer motion.
REQ-023 Full and in_done=1 and no pop same edge: entry discarded, contents unchanged, drop_cnt increments (saturating).
REQ-024 Full and push and pop same edge: pop and push both performed, count stays DEPTH, no drop.
REQ-025 Empty and push and out_ready=1 same edge: push only (out_valid was 0), count becomes 1.
REQ-026 Non-full, non-empty push and pop same edge: count unchanged, order preserved.
REQ-027 Read/write pointers wrap modulo DEPTH; strict FIFO order across wrap.
REQ-028 full = (count==DEPTH); empty = (count==0); both registered-consistent with count every cycle.
REQ-029 X on in_result with in_done=0 has no effect on any output.

Reset
REQ-030 resetN=0 asynchronously forces: pointers 0, count 0, empty 1, full 0, out_valid 0, drop_cnt 0.
REQ-031 Storage array contents need not be reset; out_result/flags don't-care while out_valid=0.
REQ-032 Reset asserted mid-operation discards all stored entries; in_done during reset ignored.
REQ-033 First push accepted on first rising edge with resetN=1.

Verification
REQ-034 Reset, one push {fib, result 13}, out_ready=0 -> next cycle out_valid=1, out_result=13, out_is_fib=1, count=1; holds 5 cycles.
REQ-035 DEPTH=4: push 21,28,34,55 with out_ready=0 -> full=1, count=4; fifth push 89 -> drop_cnt=1, then pops return 21,28,34,55 in order, empty=1.
REQ-036 Full, simultaneous push 144 and pop -> pop returns 21, count stays 4, drop_cnt unchanged, 144 becomes last entry.
REQ-037 Push in_error=1, in_result=16'hFFFF, in_ovrflow=1 -> out_result=0, out_error=1, out_ovrflow=0; push in_ovrflow=1, result 16'hA000 -> out_ovrflow=1, out_result=16'hA000.
REQ-038 300 pushes while full, no pops -> drop_cnt saturates at 255.
REQ-039 Buffer holding 3 entries, drop_cnt=5, resetN pulsed low mid-cycle -> immediately count=0, empty=1, out_valid=0, drop_cnt=0; 10 push/pop pairs afterward stream in order across pointer wrap.
